frame_rr_arbiter: RTL

Frame-granular round-robin arbiter between the three ingress port datapaths and the shared packet-memory write port. A grant is held for a complete frame, from its start-of-frame word to its end-of-frame word, so frame words are never interleaved in memory. Per-port valid/ready handshakes give backpressure, and memory-full stalls propagate back to the sources. Sits between the port RX logic and the memory bank write interface.

---
 rtl/frame_rr_arbiter_if.sv | 52 +++++
 rtl/frame_rr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/frame_rr_arbiter_if.sv
// Ingress-port and memory-write bundle for frame_rr_arbiter.
// master: the port RX logic / memory side that drives the i_* signals.
// slave: the arbiter itself.
interface frame_rr_arbiter_if;
  localparam int unsigned NPORTS = 3;
  localparam int unsigned DW     = 32;
  localparam int unsigned IW     = 2;
  localparam int unsigned XW     = 2;
  localparam int unsigned PW     = 2;

  // ingress side
  logic [NPORTS-1:0] i_valid;
  logic [DW-1:0]     i_data_port1;
  logic [DW-1:0]     i_data_port2;
  logic [DW-1:0]     i_data_port3;
  logic [IW-1:0]     i_info_port1;
  logic [IW-1:0]     i_info_port2;
  logic [IW-1:0]     i_info_port3;
  logic [XW-1:0]     i_extra_byte1;
  logic [XW-1:0]     i_extra_byte2;
  logic [XW-1:0]     i_extra_byte3;
  logic              i_mem_ready;
  logic [NPORTS-1:0] o_ready;

  // memory side
  logic [DW-1:0]     o_data;
  logic [PW-1:0]     o_port_num;
  logic              o_en_mem;
  logic [IW-1:0]     o_info_port;
  logic [XW-1:0]     o_extra_byte;

  // status
  logic              o_busy;
  logic [NPORTS-1:0] o_orphan;
  logic              o_abort;

  modport master (
    output i_valid, i_data_port1, i_data_port2, i_data_port3,
           i_info_port1, i_info_port2, i_info_port3,
           i_extra_byte1, i_extra_byte2, i_extra_byte3, i_mem_ready,
    input  o_ready, o_data, o_port_num, o_en_mem, o_info_port,
           o_extra_byte, o_busy, o_orphan, o_abort
  );

  modport slave (
    input  i_valid, i_data_port1, i_data_port2, i_data_port3,
           i_info_port1, i_info_port2, i_info_port3,
           i_extra_byte1, i_extra_byte2, i_extra_byte3, i_mem_ready,
    output o_ready, o_data, o_port_num, o_en_mem, o_info_port,
           o_extra_byte, o_busy, o_orphan, o_abort
  );
endinterface

// File: rtl/frame_rr_arbiter.sv
// Frame-granular round-robin arbiter: three ingress ports share one
// packet-memory write port; a grant is held from start-of-frame to
// end-of-frame so frames never interleave in memory.
// Optional feature macro: FRAME_TIMEOUT_EN -- aborts a granted frame whose
// source stops presenting words for pTIMEOUT ready cycles.
module frame_rr_arbiter #(
  parameter int unsigned pPORT_WIDTH = 3
`ifdef FRAME_TIMEOUT_EN
  , parameter int unsigned pTIMEOUT  = 64
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  frame_rr_arbiter_if.slave bus
);
  localparam int unsigned NPORTS = pPORT_WIDTH;
  localparam int unsigned DW     = 32;
  localparam int unsigned IW     = 2;
  localparam int unsigned XW     = 2;
  localparam int unsigned PW     = 2;
`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned CW     = $clog2(pTIMEOUT + 1);
`endif

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] info;
    logic [XW-1:0] xb;
  } word_t;

  state_t            state, state_next;
  logic [PW-1:0]     grant, grant_next;
  logic [PW-1:0]     last_grant, last_next;
  logic [PW-1:0]     pick;
  word_t             in_word [NPORTS];
  word_t             sel_word;
  logic              sel_valid;
  logic [NPORTS-1:0] start_bits;
  logic [NPORTS-1:0] cand;
  logic [NPORTS-1:0] ready_c;

  word_t             out_word, out_word_next;
  logic [PW-1:0]     port_q, port_next;
  logic              en_q, en_next;
  logic [NPORTS-1:0] orphan_q, orphan_next;
`ifdef FRAME_TIMEOUT_EN
  logic [CW-1:0]     cnt, cnt_next;
  logic              abort_q, abort_next;
`endif

  // Gather per-port words and select the granted port's word.
  always_comb begin
    in_word[0] = {bus.i_data_port1, bus.i_info_port1, bus.i_extra_byte1};
    in_word[1] = {bus.i_data_port2, bus.i_info_port2, bus.i_extra_byte2};
    in_word[2] = {bus.i_data_port3, bus.i_info_port3, bus.i_extra_byte3};
    start_bits = {in_word[2].info[0], in_word[1].info[0], in_word[0].info[0]};
    cand       = bus.i_valid & start_bits;
    case (grant)
      2'd1:    sel_word = in_word[1];
      2'd2:    sel_word = in_word[2];
      default: sel_word = in_word[0];
    endcase
    sel_valid = bus.i_valid[grant];
  end

  // Round-robin pick among start-word candidates, beginning after last_grant.
  always_comb begin
    pick = '0;
    case (last_grant)
      2'd0: begin
        if (cand[1])      pick = 2'd1;
        else if (cand[2]) pick = 2'd2;
        else              pick = 2'd0;
      end
      2'd1: begin
        if (cand[2])      pick = 2'd2;
        else if (cand[0]) pick = 2'd0;
        else              pick = 2'd1;
      end
      default: begin
        if (cand[0])      pick = 2'd0;
        else if (cand[1]) pick = 2'd1;
        else              pick = 2'd2;
      end
    endcase
  end

  // Next-state, ready and next-output logic.
  always_comb begin
    state_next    = state;
    grant_next    = grant;
    last_next     = last_grant;
    out_word_next = out_word;
    port_next     = port_q;
    en_next       = 1'b0;
    orphan_next   = '0;
    ready_c       = '0;
`ifdef FRAME_TIMEOUT_EN
    cnt_next      = cnt;
    abort_next    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // Non-start words cannot begin a frame: flush them regardless of memory.
        ready_c     = bus.i_valid & ~start_bits;
        orphan_next = ready_c;
        if (|cand) begin
          grant_next = pick;
          last_next  = pick;
          state_next = S_LOCKED;
`ifdef FRAME_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      S_LOCKED: begin
        ready_c = {{(NPORTS-1){1'b0}}, bus.i_mem_ready} << grant;
        if (sel_valid && bus.i_mem_ready) begin
          out_word_next = sel_word;
          port_next     = grant;
          en_next       = 1'b1;
`ifdef FRAME_TIMEOUT_EN
          cnt_next      = '0;
`endif
          if (sel_word.info[1]) state_next = S_IDLE;
        end
`ifdef FRAME_TIMEOUT_EN
        else if (bus.i_mem_ready) begin
          // Memory is ready but the source is silent: count toward abort.
          if (cnt == CW'(pTIMEOUT - 1)) begin
            abort_next = 1'b1;
            port_next  = grant;
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= PW'(NPORTS - 1);
      out_word   <= '0;
      port_q     <= '0;
      en_q       <= 1'b0;
      orphan_q   <= '0;
`ifdef FRAME_TIMEOUT_EN
      cnt        <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_next;
      out_word   <= out_word_next;
      port_q     <= port_next;
      en_q       <= en_next;
      orphan_q   <= orphan_next;
`ifdef FRAME_TIMEOUT_EN
      cnt        <= cnt_next;
      abort_q    <= abort_next;
`endif
    end
  end

  assign bus.o_ready      = ready_c;
  assign bus.o_data       = out_word.data;
  assign bus.o_info_port  = out_word.info;
  assign bus.o_extra_byte = out_word.xb;
  assign bus.o_port_num   = port_q;
  assign bus.o_en_mem     = en_q;
  assign bus.o_orphan     = orphan_q;
  assign bus.o_busy       = (state == S_LOCKED);
`ifdef FRAME_TIMEOUT_EN
  assign bus.o_abort      = abort_q;
`else
  assign bus.o_abort      = 1'b0;
`endif

endmodule
